// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared widths, FSM states and peak record for the spectrum peak reader
package spectrum_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 8;
    localparam int BIN_LAST = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] bin;
        logic [DATA_W-1:0] mag;
    } peak_t;

endpackage

// File: rtl/peak_top2.sv
// rtl/peak_top2.sv - registered two-slot insertion sorter for candidate peaks
module peak_top2
    import spectrum_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              cand_valid_i,
    input  logic [ADDR_W-1:0] cand_bin_i,
    input  logic [DATA_W-1:0] cand_mag_i,
    output peak_t             peak1_o,
    output peak_t             peak2_o,
    output logic [1:0]        peak_cnt_o
);

    peak_t      p1_q, p2_q;
    peak_t      cand;
    logic [1:0] cnt_q;

    assign cand.bin = cand_bin_i;
    assign cand.mag = cand_mag_i;

    // Strict compares: an equal-magnitude later bin never displaces an earlier one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_q  <= '0;
            p2_q  <= '0;
            cnt_q <= 2'd0;
        end else if (clear_i) begin
            p1_q  <= '0;
            p2_q  <= '0;
            cnt_q <= 2'd0;
        end else if (cand_valid_i) begin
            if (cand_mag_i > p1_q.mag) begin
                p2_q <= p1_q;
                p1_q <= cand;
            end else if (cand_mag_i > p2_q.mag) begin
                p2_q <= cand;
            end
            if (cnt_q != 2'd2) begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

    assign peak1_o    = p1_q;
    assign peak2_o    = p2_q;
    assign peak_cnt_o = cnt_q;

endmodule

// File: rtl/spectrum_peak_reader.sv
// rtl/spectrum_peak_reader.sv - sweeps the FFT magnitude RAM once and reports the two largest local maxima
module spectrum_peak_reader
    import spectrum_pkg::*;
#(
    parameter int                RD_LAT  = 1,
    parameter logic [DATA_W-1:0] MIN_MAG = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_i,
    input  logic              wr_done_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        peak_cnt_o,
    output logic [ADDR_W-1:0] peak1_bin_o,
    output logic [DATA_W-1:0] peak1_mag_o,
    output logic [ADDR_W-1:0] peak2_bin_o,
    output logic [DATA_W-1:0] peak2_mag_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BIN_LAST);
    localparam logic [ADDR_W-1:0] DRAIN_END = ADDR_W'(RD_LAT);

    state_t            state_q;
    logic              rd_en_q, busy_q, done_q, wr_done_q;
    logic [ADDR_W-1:0] rd_addr_q, drain_q;

    logic [RD_LAT-1:0]             vld_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] tag_q;
    logic [2:0][DATA_W-1:0]        win_mag_q;
    logic [2:0][ADDR_W-1:0]        win_bin_q;
    logic [2:0]                    win_vld_q;
    logic                          shift_q;

    logic  start, clear_res, cand_valid;
    peak_t peak1, peak2;

    assign start     = (state_q == IDLE) && wr_done_i && !wr_done_q;
    assign clear_res = !key_i || start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_done_q <= 1'b0;
        end else if (!key_i) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_done_q <= wr_done_i;
        end else begin
            wr_done_q <= wr_done_i;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= READ;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                    end
                end
                READ: begin
                    if (rd_addr_q == LAST_ADDR) begin
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        drain_q   <= '0;
                        state_q   <= DRAIN;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Covers RAM latency plus the window stage and the sorter stage.
                    if (drain_q == DRAIN_END) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            tag_q     <= '0;
            win_mag_q <= '0;
            win_bin_q <= '0;
            win_vld_q <= '0;
            shift_q   <= 1'b0;
        end else if (clear_res) begin
            vld_q     <= '0;
            win_vld_q <= '0;
            shift_q   <= 1'b0;
        end else begin
            vld_q[0] <= rd_en_q;
            tag_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            shift_q <= vld_q[RD_LAT-1];
            if (vld_q[RD_LAT-1]) begin
                win_mag_q <= {rd_data_i, win_mag_q[2], win_mag_q[1]};
                win_bin_q <= {tag_q[RD_LAT-1], win_bin_q[2], win_bin_q[1]};
                win_vld_q <= {1'b1, win_vld_q[2], win_vld_q[1]};
            end
        end
    end

    // Index 0 = prev, 1 = cur, 2 = next; evaluated once per newly shifted sample.
    assign cand_valid = shift_q && (&win_vld_q)
                     && (win_bin_q[1] != '0) && (win_bin_q[1] != LAST_ADDR)
                     && (win_mag_q[1] > win_mag_q[0])
                     && (win_mag_q[1] >= win_mag_q[2])
                     && (win_mag_q[1] > MIN_MAG);

    peak_top2 u_top2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_res),
        .cand_valid_i (cand_valid),
        .cand_bin_i   (win_bin_q[1]),
        .cand_mag_i   (win_mag_q[1]),
        .peak1_o      (peak1),
        .peak2_o      (peak2),
        .peak_cnt_o   (peak_cnt_o)
    );

    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign peak1_bin_o = peak1.bin;
    assign peak1_mag_o = peak1.mag;
    assign peak2_bin_o = peak2.bin;
    assign peak2_mag_o = peak2.mag;

endmodule

// File: tb/tb_spectrum_peak_reader.sv
// tb/tb_spectrum_peak_reader.sv - directed-vector bench for spectrum_peak_reader
module tb_spectrum_peak_reader;

    logic        clk = 1'b0;
    logic        rst_n, key, wr_done;
    logic [15:0] mem [0:255];

    logic [15:0] rd_data1 = '0, rd_data2 = '0;
    logic        rd_en1, busy1, done1, rd_en2, busy2, done2;
    logic [7:0]  rd_addr1, p1b1, p2b1, rd_addr2, p1b2, p2b2;
    logic [15:0] p1m1, p2m1, p1m2, p2m2;
    logic [1:0]  cnt1, cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en1) rd_data1 <= mem[rd_addr1];
        if (rd_en2) rd_data2 <= mem[rd_addr2];
    end

    spectrum_peak_reader u_dut (
        .clk(clk), .rst_n(rst_n), .key_i(key), .wr_done_i(wr_done), .rd_data_i(rd_data1),
        .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .busy_o(busy1), .done_o(done1),
        .peak_cnt_o(cnt1), .peak1_bin_o(p1b1), .peak1_mag_o(p1m1),
        .peak2_bin_o(p2b1), .peak2_mag_o(p2m1)
    );

    spectrum_peak_reader #(.RD_LAT(1), .MIN_MAG(16'd100)) u_thr (
        .clk(clk), .rst_n(rst_n), .key_i(key), .wr_done_i(wr_done), .rd_data_i(rd_data2),
        .rd_en_o(rd_en2), .rd_addr_o(rd_addr2), .busy_o(busy2), .done_o(done2),
        .peak_cnt_o(cnt2), .peak1_bin_o(p1b2), .peak1_mag_o(p1m2),
        .peak2_bin_o(p2b2), .peak2_mag_o(p2m2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic res1(input string tag, input int b1, input int m1, input int b2, input int m2, input int c);
        check({tag, "_p1bin"}, 32'(p1b1), b1);
        check({tag, "_p1mag"}, 32'(p1m1), m1);
        check({tag, "_p2bin"}, 32'(p2b1), b2);
        check({tag, "_p2mag"}, 32'(p2m1), m2);
        check({tag, "_cnt"},   32'(cnt1), c);
    endtask

    task automatic res2(input string tag, input int b1, input int m1, input int b2, input int m2, input int c);
        check({tag, "_thr_p1bin"}, 32'(p1b2), b1);
        check({tag, "_thr_p1mag"}, 32'(p1m2), m1);
        check({tag, "_thr_p2bin"}, 32'(p2b2), b2);
        check({tag, "_thr_p2mag"}, 32'(p2m2), m2);
        check({tag, "_thr_cnt"},   32'(cnt2), c);
    endtask

    task automatic fill(input logic [15:0] floor_v);
        for (int i = 0; i < 256; i++) mem[i] = floor_v;
    endtask

    task automatic rearm();
        wr_done = 1'b0;
        key     = 1'b0;
        @(negedge clk);
        key = 1'b1;
    endtask

    // Raises wr_done and follows one sweep: contiguous 0..128 reads, done RD_LAT+2 after last read.
    task automatic sweep(input string tag);
        int n_rd = 0, first = -1, last = -1, d1 = -1, d2 = -1, addr_err = 0;
        wr_done = 1'b0;
        @(negedge clk);
        wr_done = 1'b1;
        for (int c = 0; c < 400 && (d1 < 0 || d2 < 0); c++) begin
            @(negedge clk);
            if (rd_en1) begin
                if (32'(rd_addr1) != n_rd) addr_err++;
                if (first < 0) first = c;
                n_rd++;
                last = c;
            end
            if (done1 && d1 < 0) d1 = c;
            if (done2 && d2 < 0) d2 = c;
        end
        check({tag, "_rd_count"}, n_rd, 129);
        check({tag, "_rd_addr_seq"}, addr_err, 0);
        check({tag, "_rd_contig"}, last - first, 128);
        check({tag, "_done_lat"}, d1 - last, 3);
        check({tag, "_thr_done_lat"}, d2 - last, 3);
        check({tag, "_busy_at_done"}, 32'(busy1), 0);
    endtask

    initial begin
        int found, n;
        rst_n   = 1'b0;
        key     = 1'b1;
        wr_done = 1'b0;
        fill(16'd0);
        repeat (2) @(negedge clk);
        check("rst_rd_en", 32'(rd_en1), 0);
        check("rst_busy",  32'(busy1), 0);
        check("rst_done",  32'(done1), 0);
        check("rst_addr",  32'(rd_addr1), 0);
        res1("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single tone
        fill(16'd5);
        mem[19] = 16'd400; mem[20] = 16'd900; mem[21] = 16'd400;
        sweep("t1");
        res1("t1", 20, 900, 0, 0, 1);
        res2("t1", 20, 900, 0, 0, 1);

        // 2: two tones, then a third weaker one
        fill(16'd3);
        mem[10] = 16'd700; mem[45] = 16'd1200;
        rearm();
        sweep("t2a");
        res1("t2a", 45, 1200, 10, 700, 2);
        mem[80] = 16'd300;
        rearm();
        sweep("t2b");
        res1("t2b", 45, 1200, 10, 700, 2);

        // 3: edge bins excluded, equal-magnitude tie, plateau
        fill(16'd3);
        mem[0] = 16'd5000; mem[128] = 16'd4000;
        mem[30] = 16'd500; mem[60] = 16'd500;
        mem[70] = 16'd800; mem[71] = 16'd800;
        rearm();
        sweep("t3");
        res1("t3", 70, 800, 30, 500, 2);

        // 4: candidate equal to threshold is rejected
        fill(16'd0);
        mem[50] = 16'd100;
        rearm();
        sweep("t4");
        res2("t4", 0, 0, 0, 0, 0);
        res1("t4", 50, 100, 0, 0, 1);

        // 5: key pulse mid-sweep
        rearm();
        wr_done = 1'b0;
        @(negedge clk);
        wr_done = 1'b1;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(negedge clk);
            if (rd_en1 && rd_addr1 == 8'd60) found = 1;
        end
        check("t5_reach_60", found, 1);
        key = 1'b0;
        @(negedge clk);
        check("t5_rd_en", 32'(rd_en1), 0);
        check("t5_busy",  32'(busy1), 0);
        check("t5_done",  32'(done1), 0);
        res1("t5_clr", 0, 0, 0, 0, 0);
        key = 1'b1;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (rd_en1) n++;
        end
        check("t5_no_self_restart", n, 0);
        sweep("t5");
        res1("t5", 50, 100, 0, 0, 1);

        // 6: wr_done edges ignored in DONE; key re-arms
        wr_done = 1'b0;
        @(negedge clk);
        wr_done = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_en1) n++;
        end
        check("t6_ignored_rd", n, 0);
        check("t6_done_held", 32'(done1), 1);
        res1("t6_held", 50, 100, 0, 0, 1);
        fill(16'd1);
        mem[100] = 16'd2000;
        rearm();
        sweep("t6");
        res1("t6", 100, 2000, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
